// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, decoder state encoding, event payload and ASCII mapping
// for the PS/2 key decoder.
package ps2_key_decoder_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] ascii;
        logic [7:0] scan;
    } evt_t;

    // Scan-code set 2 to ASCII; letters follow 'upper', digits ignore it.
    function automatic logic [7:0] scan2ascii(input logic [7:0] code, input logic upper);
        logic [7:0] lc;
        lc = 8'h00;
        case (code)
            8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
            8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
            8'h43: lc = 8'h69;  8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;  8'h4D: lc = 8'h70;
            8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;  8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;
            8'h3C: lc = 8'h75;  8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
            8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
            8'h16: lc = 8'h31;  8'h1E: lc = 8'h32;  8'h26: lc = 8'h33;  8'h25: lc = 8'h34;
            8'h2E: lc = 8'h35;  8'h36: lc = 8'h36;  8'h3D: lc = 8'h37;  8'h3E: lc = 8'h38;
            8'h46: lc = 8'h39;  8'h45: lc = 8'h30;
            8'h29: lc = 8'h20;
            8'h5A: lc = 8'h0D;
            default: lc = 8'h00;
        endcase
        if (upper && (lc >= 8'h61) && (lc <= 8'h7A)) begin
            lc = lc - 8'h20;
        end
        return lc;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_evt_fifo.sv
// Synchronous event FIFO with valid/ready pop; simultaneous push and pop succeed when full.
module ps2_key_decoder_evt_fifo
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  evt_t din,
    input  logic ready,
    output logic valid,
    output evt_t head,
    output logic full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    evt_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             pop;
    logic             wr_en;

    always_comb begin
        valid = (count != '0);
        full  = (count == OCC_W'(DEPTH));
        head  = mem[rd_ptr];
        pop   = valid && ready;
        wr_en = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: prefix tracking, modifier state, typematic suppression,
// and key events delivered through a small FIFO.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_code_valid,
    input  logic [7:0]       i_code,
    output logic             o_evt_valid,
    input  logic             i_evt_ready,
    output logic [7:0]       o_evt_scan,
    output logic [7:0]       o_evt_ascii,
    output logic             o_evt_make,
    output logic             o_evt_ext,
    output logic             o_shift,
    output logic             o_caps,
    output logic [CNT_W-1:0] o_press_cnt,
    output logic             o_overflow
);

    state_t           state_q, state_d;
    logic             make_c, brk_c, ext_c;
    logic             is_prefix_c, is_ctrl_c, is_mod_c;
    logic [8:0]       key_c, held_q, held_d;
    logic             new_make_c, push_c, pop_c;
    logic             shift_l_q, shift_r_q, shift_l_d, shift_r_d, caps_d;
    logic [CNT_W-1:0] cnt_d;
    logic             fifo_full;
    evt_t             evt_c, head;

    always_comb begin
        is_prefix_c = (i_code == SC_EXT) || (i_code == SC_BRK);
        is_ctrl_c   = (i_code == SC_BAT) || (i_code == SC_ACK) || (i_code == SC_RESEND) ||
                      (i_code == SC_ECHO) || (i_code == SC_PAUSE);
        is_mod_c    = (i_code == SC_LSHIFT) || (i_code == SC_RSHIFT) || (i_code == SC_CAPS);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_code_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_code == SC_EXT)      state_d = ST_EXT;
                    else if (i_code == SC_BRK) state_d = ST_BRK;
                end
                ST_EXT: begin
                    if (i_code == SC_BRK)      state_d = ST_EXT_BRK;
                    else if (i_code != SC_EXT) state_d = ST_IDLE;
                end
                ST_BRK, ST_EXT_BRK: begin
                    if (!is_prefix_c) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Decoded key action for the byte currently presented
    always_comb begin
        make_c = 1'b0;
        brk_c  = 1'b0;
        ext_c  = 1'b0;
        if (i_code_valid) begin
            case (state_q)
                ST_IDLE:    make_c = !is_prefix_c && !is_ctrl_c;
                ST_EXT: begin
                    make_c = !is_prefix_c;
                    ext_c  = 1'b1;
                end
                ST_BRK:     brk_c = !is_prefix_c;
                ST_EXT_BRK: begin
                    brk_c = !is_prefix_c;
                    ext_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Modifiers feed the ASCII mapping with their pre-update values
    always_comb begin
        key_c       = {ext_c, i_code};
        new_make_c  = make_c && (key_c != held_q);
        push_c      = new_make_c || brk_c;
        pop_c       = o_evt_valid && i_evt_ready;
        evt_c.ext   = ext_c;
        evt_c.make  = make_c;
        evt_c.ascii = ext_c ? 8'h00 : scan2ascii(i_code, o_shift ^ o_caps);
        evt_c.scan  = i_code;

        held_d    = held_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        caps_d    = o_caps;
        cnt_d     = o_press_cnt;
        if (new_make_c) begin
            held_d = key_c;
            if (!ext_c) begin
                if (i_code == SC_LSHIFT) shift_l_d = 1'b1;
                if (i_code == SC_RSHIFT) shift_r_d = 1'b1;
                if (i_code == SC_CAPS)   caps_d    = !o_caps;
            end
        end
        if (brk_c) begin
            if (key_c == held_q) held_d = '0;
            if (!ext_c) begin
                if (i_code == SC_LSHIFT) shift_l_d = 1'b0;
                if (i_code == SC_RSHIFT) shift_r_d = 1'b0;
                if (!is_mod_c)           cnt_d     = o_press_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q      <= '0;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            o_shift     <= 1'b0;
            o_caps      <= 1'b0;
            o_press_cnt <= '0;
            o_overflow  <= 1'b0;
        end else begin
            held_q      <= held_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            o_shift     <= shift_l_d || shift_r_d;
            o_caps      <= caps_d;
            o_press_cnt <= cnt_d;
            if (push_c && fifo_full && !pop_c) o_overflow <= 1'b1;
        end
    end

    ps2_key_decoder_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   (evt_c),
        .ready (i_evt_ready),
        .valid (o_evt_valid),
        .head  (head),
        .full  (fifo_full)
    );

    always_comb begin
        o_evt_scan  = head.scan;
        o_evt_ascii = head.ascii;
        o_evt_make  = head.make;
        o_evt_ext   = head.ext;
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: byte table with per-byte modifier/counter checks,
// FIFO-ordered event scoreboard, plus overflow, full push/pop and reset corners.
module tb_ps2_key_decoder;
    import ps2_key_decoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_code_valid;
    logic [7:0] i_code;
    logic       o_evt_valid;
    logic       i_evt_ready;
    logic [7:0] o_evt_scan;
    logic [7:0] o_evt_ascii;
    logic       o_evt_make;
    logic       o_evt_ext;
    logic       o_shift;
    logic       o_caps;
    logic [7:0] o_press_cnt;
    logic       o_overflow;

    ps2_key_decoder #(.DEPTH(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_code_valid (i_code_valid),
        .i_code       (i_code),
        .o_evt_valid  (o_evt_valid),
        .i_evt_ready  (i_evt_ready),
        .o_evt_scan   (o_evt_scan),
        .o_evt_ascii  (o_evt_ascii),
        .o_evt_make   (o_evt_make),
        .o_evt_ext    (o_evt_ext),
        .o_shift      (o_shift),
        .o_caps       (o_caps),
        .o_press_cnt  (o_press_cnt),
        .o_overflow   (o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       has_evt;
        logic [7:0] ascii;
        logic       make;
        logic       ext;
        logic       shift;
        logic       caps;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];
    evt_t exp_q[$];
    evt_t mon_act;
    evt_t mon_exp;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pops  = 0;
    int   pops_base;

    function automatic void add(input logic [7:0] code, input logic has_evt, input logic [7:0] ascii,
                                input logic make, input logic ext, input logic shift,
                                input logic caps, input logic [7:0] cnt);
        vec_t v;
        v.code = code; v.has_evt = has_evt; v.ascii = ascii; v.make = make;
        v.ext = ext; v.shift = shift; v.caps = caps; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic evt_t mk_evt(input logic ext, input logic make, input logic [7:0] ascii,
                                    input logic [7:0] scan);
        evt_t e;
        e.ext = ext; e.make = make; e.ascii = ascii; e.scan = scan;
        return e;
    endfunction

    // Called at posedge+1; leaves at the following posedge+1
    task automatic send_byte(input logic [7:0] c);
        i_code       = c;
        i_code_valid = 1'b1;
        @(posedge clk); #1;
        i_code_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every accepted head is compared against the oldest expected event
    always @(negedge clk) begin
        if (!rst && o_evt_valid && i_evt_ready) begin
            pops++;
            n_cmp++;
            mon_act = mk_evt(o_evt_ext, o_evt_make, o_evt_ascii, o_evt_scan);
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL evt_unexpected: got %h, required no event", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_err++;
                    $display("FAIL evt_payload: got %h, required %h", mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        i_code_valid = 1'b0;
        i_code       = 8'h00;
        i_evt_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_evt_valid), 32'd0);
        chk("rst_cnt", 32'(o_press_cnt), 32'd0);
        chk("rst_flags", {28'd0, o_shift, o_caps, o_overflow, o_evt_make}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        //  code  evt  ascii  make ext shift caps cnt
        add(8'h1C, 1, 8'h61, 1, 0, 0, 0, 8'd0);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
        add(8'h1C, 1, 8'h61, 0, 0, 0, 0, 8'd1);
        add(8'h12, 1, 8'h00, 1, 0, 1, 0, 8'd1);
        add(8'h1C, 1, 8'h41, 1, 0, 1, 0, 8'd1);
        add(8'hF0, 0, 8'h00, 0, 0, 1, 0, 8'd1);
        add(8'h1C, 1, 8'h41, 0, 0, 1, 0, 8'd2);
        add(8'hF0, 0, 8'h00, 0, 0, 1, 0, 8'd2);
        add(8'h12, 1, 8'h00, 0, 0, 0, 0, 8'd2);
        add(8'h1C, 1, 8'h61, 1, 0, 0, 0, 8'd2);
        add(8'h1C, 0, 8'h00, 0, 0, 0, 0, 8'd2);
        add(8'h1C, 0, 8'h00, 0, 0, 0, 0, 8'd2);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd2);
        add(8'h1C, 1, 8'h61, 0, 0, 0, 0, 8'd3);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd3);
        add(8'h75, 1, 8'h00, 1, 1, 0, 0, 8'd3);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd3);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd3);
        add(8'h75, 1, 8'h00, 0, 1, 0, 0, 8'd3);
        add(8'h58, 1, 8'h00, 1, 0, 0, 1, 8'd3);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 1, 8'd3);
        add(8'h58, 1, 8'h00, 0, 0, 0, 1, 8'd3);
        add(8'h1C, 1, 8'h41, 1, 0, 0, 1, 8'd3);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 1, 8'd3);
        add(8'h1C, 1, 8'h41, 0, 0, 0, 1, 8'd4);
        add(8'h12, 1, 8'h00, 1, 0, 1, 1, 8'd4);
        add(8'h1C, 1, 8'h61, 1, 0, 1, 1, 8'd4);
        add(8'hF0, 0, 8'h00, 0, 0, 1, 1, 8'd4);
        add(8'h1C, 1, 8'h61, 0, 0, 1, 1, 8'd5);
        add(8'hF0, 0, 8'h00, 0, 0, 1, 1, 8'd5);
        add(8'h12, 1, 8'h00, 0, 0, 0, 1, 8'd5);
        add(8'h58, 1, 8'h00, 1, 0, 0, 0, 8'd5);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd5);
        add(8'h58, 1, 8'h00, 0, 0, 0, 0, 8'd5);
        add(8'h16, 1, 8'h31, 1, 0, 0, 0, 8'd5);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd5);
        add(8'h16, 1, 8'h31, 0, 0, 0, 0, 8'd6);
        add(8'h45, 1, 8'h30, 1, 0, 0, 0, 8'd6);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd6);
        add(8'h45, 1, 8'h30, 0, 0, 0, 0, 8'd7);
        add(8'h29, 1, 8'h20, 1, 0, 0, 0, 8'd7);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd7);
        add(8'h29, 1, 8'h20, 0, 0, 0, 0, 8'd8);
        add(8'h5A, 1, 8'h0D, 1, 0, 0, 0, 8'd8);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd8);
        add(8'h5A, 1, 8'h0D, 0, 0, 0, 0, 8'd9);
        add(8'hAA, 0, 8'h00, 0, 0, 0, 0, 8'd9);
        add(8'hFA, 0, 8'h00, 0, 0, 0, 0, 8'd9);
        add(8'hE1, 0, 8'h00, 0, 0, 0, 0, 8'd9);
        add(8'h1C, 1, 8'h61, 1, 0, 0, 0, 8'd9);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd9);
        add(8'h1C, 1, 8'h61, 0, 0, 0, 0, 8'd10);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd10);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd10);
        add(8'h1C, 1, 8'h61, 0, 0, 0, 0, 8'd11);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd11);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd11);
        add(8'h6B, 1, 8'h00, 1, 1, 0, 0, 8'd11);
        add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 8'd11);
        add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 8'd11);
        add(8'h6B, 1, 8'h00, 0, 1, 0, 0, 8'd11);

        foreach (vecs[i]) begin
            if (vecs[i].has_evt)
                exp_q.push_back(mk_evt(vecs[i].ext, vecs[i].make, vecs[i].ascii, vecs[i].code));
            send_byte(vecs[i].code);
            chk($sformatf("v%0d_shift", i), 32'(o_shift), 32'(vecs[i].shift));
            chk($sformatf("v%0d_caps", i), 32'(o_caps), 32'(vecs[i].caps));
            chk($sformatf("v%0d_cnt", i), 32'(o_press_cnt), 32'(vecs[i].cnt));
        end
        drain("table_drain");
        chk("table_overflow", 32'(o_overflow), 32'd0);

        // Overflow: six distinct makes into a four-entry FIFO with no consumer
        i_evt_ready = 1'b0;
        pops_base   = pops;
        exp_q.push_back(mk_evt(1'b0, 1'b1, 8'h61, 8'h1C));
        exp_q.push_back(mk_evt(1'b0, 1'b1, 8'h62, 8'h32));
        exp_q.push_back(mk_evt(1'b0, 1'b1, 8'h63, 8'h21));
        exp_q.push_back(mk_evt(1'b0, 1'b1, 8'h64, 8'h23));
        send_byte(8'h1C);
        chk("ovf_latency_valid", 32'(o_evt_valid), 32'd1);
        send_byte(8'h32);
        send_byte(8'h21);
        send_byte(8'h23);
        chk("ovf_not_yet", 32'(o_overflow), 32'd0);
        send_byte(8'h24);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        send_byte(8'h2B);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_head_stable", 32'(o_evt_scan), 32'h1C);
        chk("ovf_cnt_unchanged", 32'(o_press_cnt), 32'd11);
        i_evt_ready = 1'b1;
        drain("ovf_drain");
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_pop_count", 32'(pops - pops_base), 32'd4);
        chk("ovf_empty", 32'(o_evt_valid), 32'd0);
        chk("ovf_sticky", 32'(o_overflow), 32'd1);

        // Reset with a pending break prefix
        send_byte(8'hF0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst2_valid", 32'(o_evt_valid), 32'd0);
        chk("rst2_head", {o_evt_ext, o_evt_make, o_evt_ascii, o_evt_scan}, 32'd0);
        chk("rst2_cnt", 32'(o_press_cnt), 32'd0);
        chk("rst2_flags", {29'd0, o_shift, o_caps, o_overflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(mk_evt(1'b0, 1'b1, 8'h61, 8'h1C));
        send_byte(8'h1C);
        drain("rst2_drain");
        chk("rst2_cnt_after", 32'(o_press_cnt), 32'd0);

        // Full FIFO: push and pop in the same cycle both succeed
        i_evt_ready = 1'b0;
        pops_base   = pops;
        exp_q.push_back(mk_evt(1'b0, 1'b1, 8'h62, 8'h32));
        exp_q.push_back(mk_evt(1'b0, 1'b1, 8'h63, 8'h21));
        exp_q.push_back(mk_evt(1'b0, 1'b1, 8'h64, 8'h23));
        exp_q.push_back(mk_evt(1'b0, 1'b1, 8'h65, 8'h24));
        send_byte(8'h32);
        send_byte(8'h21);
        send_byte(8'h23);
        send_byte(8'h24);
        exp_q.push_back(mk_evt(1'b0, 1'b1, 8'h66, 8'h2B));
        i_evt_ready = 1'b1;
        send_byte(8'h2B);
        chk("full_pushpop_ovf", 32'(o_overflow), 32'd0);
        drain("full_drain");
        repeat (3) @(posedge clk);
        #1;
        chk("full_pop_count", 32'(pops - pops_base), 32'd5);
        chk("full_overflow_end", 32'(o_overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
